// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands in a small FIFO, issues one at a time to a registered ALU,
// waits out its latency and returns the captured result over a valid/ready channel.
module alu_op_sequencer #(
    parameter int              DATA_W     = 32,
    parameter int              SEL_W      = 3,
    parameter int              ALU_LAT    = 1,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [SEL_W-1:0] IDLE_SEL  = 3'b111
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic [DATA_W-1:0]               i_cmd_a,
    input  logic [DATA_W-1:0]               i_cmd_b,
    input  logic [SEL_W-1:0]                i_cmd_sel,
    output logic [DATA_W-1:0]               o_alu_a,
    output logic [DATA_W-1:0]               o_alu_b,
    output logic [SEL_W-1:0]                o_alu_sel,
    input  logic [DATA_W-1:0]               i_alu_r,
    input  logic                            i_alu_zflag,
    output logic                            o_res_valid,
    input  logic                            i_res_ready,
    output logic [DATA_W-1:0]               o_res_r,
    output logic                            o_res_zflag,
    output logic [SEL_W-1:0]                o_res_sel,
    output logic                            o_busy,
    output logic [$clog2(FIFO_DEPTH):0]     o_cmd_count,
    output logic [1:0]                      dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(ALU_LAT + 2);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and a raised valid holds its payload until taken.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_HOLD} state_t;

    state_t             state;
    logic [DATA_W-1:0]  fifo_a   [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_b   [FIFO_DEPTH];
    logic [SEL_W-1:0]   fifo_sel [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [LAT_W-1:0]   wait_cnt;
    logic [SEL_W-1:0]   tag;
    logic               push;
    logic               pop;

    assign o_cmd_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign o_cmd_count = count;
    assign o_busy      = (state != S_IDLE) || (count != '0);
    assign dbg_state   = state;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= i_cmd_a;
            fifo_b[wr_ptr]   <= i_cmd_b;
            fifo_sel[wr_ptr] <= i_cmd_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            tag         <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_sel   <= IDLE_SEL;
            o_res_valid <= 1'b0;
            o_res_r     <= '0;
            o_res_zflag <= 1'b0;
            o_res_sel   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_alu_a   <= fifo_a[rd_ptr];
                        o_alu_b   <= fifo_b[rd_ptr];
                        o_alu_sel <= fifo_sel[rd_ptr];
                        tag       <= fifo_sel[rd_ptr];
                        wait_cnt  <= LAT_W'(ALU_LAT);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= LAT_W'(1)) begin
                        wait_cnt <= '0;
                        state    <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    o_res_r     <= i_alu_r;
                    o_res_zflag <= i_alu_zflag;
                    o_res_sel   <= tag;
                    o_res_valid <= 1'b1;
                    o_alu_sel   <= IDLE_SEL;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: registered XOR ALU stub, queue-based scoreboard,
// directed timing/reset scenarios and randomized traffic with random backpressure.
module tb_alu_op_sequencer;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int EW = SW + 1 + DW;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [SW-1:0] cmd_sel;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [SW-1:0] alu_sel;
    logic [DW-1:0] alu_r;
    logic          alu_zflag;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_r;
    logic          res_zflag;
    logic [SW-1:0] res_sel;
    logic          busy;
    logic [2:0]    cmd_count;
    logic [1:0]    dbg_state;

    logic          dir_ready;
    logic          rand_ready;
    logic          rand_en;
    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_pass;
    int            n_results;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .i_cmd_sel   (cmd_sel),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_sel   (alu_sel),
        .i_alu_r     (alu_r),
        .i_alu_zflag (alu_zflag),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_r     (res_r),
        .o_res_zflag (res_zflag),
        .o_res_sel   (res_sel),
        .o_busy      (busy),
        .o_cmd_count (cmd_count),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // registered one-cycle ALU stub: r = a ^ b
    always @(posedge clk) begin
        alu_r     <= alu_a ^ alu_b;
        alu_zflag <= ((alu_a ^ alu_b) == '0);
    end

    assign res_ready = rand_en ? rand_ready : dir_ready;

    initial begin
        rand_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rand_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // scoreboard monitor: any presented result must match the head of the queue
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                check("stale_result_valid", 64'(res_valid), 64'd0);
            end else begin
                check("result", 64'({res_sel, res_zflag, res_r}), 64'(exp_q[0]));
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    n_results++;
                end
            end
        end
    end

    // driver: present one command, wait for acceptance (bounded)
    task automatic push_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] sel);
        int n;
        logic acc;
        logic [DW-1:0] r;
        n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = sel;
        do begin
            acc = cmd_ready;
            @(posedge clk);
            n++;
            if (acc) begin
                r = a ^ b;
                exp_q.push_back({sel, (r == '0), r});
            end
            #1;
        end while (!acc && n < 300);
        if (!acc) check("push_timeout", 64'(acc), 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_count_zero", 64'(cmd_count), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_cmd_count"}, 64'(cmd_count), 64'd0);
        check({tag, "_alu_a"},     64'(alu_a), 64'd0);
        check({tag, "_alu_b"},     64'(alu_b), 64'd0);
        check({tag, "_alu_sel"},   64'(alu_sel), 64'd7);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_r"},     64'(res_r), 64'd0);
        check({tag, "_res_zflag"}, 64'(res_zflag), 64'd0);
        check({tag, "_res_sel"},   64'(res_sel), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
    endtask

    initial begin
        logic [SW-1:0] wrap_sels [5];
        int n;
        n_checks = 0;
        n_pass = 0;
        n_results = 0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_sel = '0;
        dir_ready = 1'b1;
        rand_en = 1'b0;

        // power-on reset, asserted between edges
        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        tick(2);
        rst = 1'b0;
        tick(2);

        // single op with timing: push at edge T
        push_cmd(32'h0C041820, 32'h24208100, 3'b000);
        check("t0_res_valid", 64'(res_valid), 64'd0);
        tick(1);
        check("t1_alu_a",   64'(alu_a), 64'h0C041820);
        check("t1_alu_b",   64'(alu_b), 64'h24208100);
        check("t1_alu_sel", 64'(alu_sel), 64'd0);
        check("t1_busy",    64'(busy), 64'd1);
        tick(1);
        check("t2_res_valid", 64'(res_valid), 64'd0);
        tick(1);
        check("t3_res_valid", 64'(res_valid), 64'd1);
        check("t3_res_r",     64'(res_r), 64'h28249920);
        check("t3_res_zflag", 64'(res_zflag), 64'd0);
        check("t3_res_sel",   64'(res_sel), 64'd0);
        check("t3_alu_sel",   64'(alu_sel), 64'd7);
        tick(1);
        check("t4_res_valid", 64'(res_valid), 64'd0);
        wait_drain(50);

        // zero flag
        push_cmd(32'h0C041820, 32'h0C041820, 3'b101);
        tick(3);
        check("zf_res_valid", 64'(res_valid), 64'd1);
        check("zf_res_r",     64'(res_r), 64'd0);
        check("zf_res_zflag", 64'(res_zflag), 64'd1);
        check("zf_res_sel",   64'(res_sel), 64'd5);
        wait_drain(50);

        // fill and backpressure
        dir_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push_cmd($urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            begin
                tick(12);
                check("full_cmd_ready", 64'(cmd_ready), 64'd0);
                check("full_cmd_count", 64'(cmd_count), 64'd4);
                check("full_res_valid", 64'(res_valid), 64'd1);
                check("full_busy",      64'(busy), 64'd1);
                dir_ready = 1'b1;
            end
        join
        wait_drain(200);
        check("results_after_fill", 64'(n_results), 64'd8);

        // reset while waiting on the ALU with two commands queued
        dir_ready = 1'b0;
        push_cmd(32'h11111111, 32'h22222222, 3'b001);
        push_cmd(32'h33333333, 32'h44444444, 3'b010);
        push_cmd(32'h55555555, 32'h66666666, 3'b011);
        push_cmd(32'h77777777, 32'h88888888, 3'b100);
        n = 0;
        while (!res_valid && n < 50) begin tick(1); n++; end
        check("midop_first_valid", 64'(res_valid), 64'd1);
        dir_ready = 1'b1;
        n = 0;
        while (alu_sel != 3'b010 && n < 50) begin tick(1); n++; end
        check("midop_issued_sel", 64'(alu_sel), 64'd2);
        check("midop_queued", 64'(cmd_count), 64'd2);
        #2 rst = 1'b1;
        exp_q.delete();
        #1 check_reset_values("midop_reset");
        tick(2);
        rst = 1'b0;
        tick(20);
        check("midop_no_stale", 64'(res_valid), 64'd0);

        // pointer wrap with fixed select pattern and random backpressure
        wrap_sels[0] = 3'b000;
        wrap_sels[1] = 3'b001;
        wrap_sels[2] = 3'b010;
        wrap_sels[3] = 3'b011;
        wrap_sels[4] = 3'b101;
        n_results = 0;
        rand_en = 1'b1;
        for (int i = 0; i < 10; i++)
            push_cmd($urandom, $urandom, wrap_sels[i % 5]);
        wait_drain(400);
        check("wrap_results", 64'(n_results), 64'd10);

        // random traffic: any select, random gaps, some zero results
        n_results = 0;
        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] a;
            a = $urandom;
            push_cmd(a, ($urandom_range(0, 4) == 0) ? a : $urandom, 3'($urandom_range(0, 7)));
            tick($urandom_range(0, 3));
        end
        wait_drain(2000);
        check("random_results", 64'(n_results), 64'd60);
        rand_en = 1'b0;
        tick(2);
        check("end_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
